// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard detection, forwarding selects and stall-cycle counter
// Shadows the E/M/W destination fields so every decision needs only decode-stage inputs.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RdD,
  input  logic             RegDstD,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             BranchD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [CNT_W-1:0] StallCount
);

  logic [4:0]       rs_e_q, rs_e_d;
  logic [4:0]       rt_e_q, rt_e_d;
  logic [4:0]       rd_e_q, rd_e_d;
  logic             reg_dst_e_q, reg_dst_e_d;
  logic             reg_write_e_q, reg_write_e_d;
  logic             mem_to_reg_e_q, mem_to_reg_e_d;
  logic [4:0]       write_reg_m_q, write_reg_m_d;
  logic             reg_write_m_q, reg_write_m_d;
  logic             mem_to_reg_m_q, mem_to_reg_m_d;
  logic [4:0]       write_reg_w_q, write_reg_w_d;
  logic             reg_write_w_q, reg_write_w_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [4:0] write_reg_e;
  logic       lw_stall;
  logic       branch_stall;
  logic       stall;

  assign write_reg_e = reg_dst_e_q ? rd_e_q : rt_e_q;

  // Hazard detection; a zero register index never matches anything.
  always_comb begin
    lw_stall     = 1'b0;
    branch_stall = 1'b0;
    ForwardAE    = 2'b00;
    ForwardBE    = 2'b00;
    ForwardAD    = 1'b0;
    ForwardBD    = 1'b0;

    if (mem_to_reg_e_q && (rt_e_q != 5'd0) && ((RsD == rt_e_q) || (RtD == rt_e_q)))
      lw_stall = 1'b1;

    if (BranchD) begin
      if (reg_write_e_q && (write_reg_e != 5'd0) &&
          ((RsD == write_reg_e) || (RtD == write_reg_e)))
        branch_stall = 1'b1;
      if (mem_to_reg_m_q && (write_reg_m_q != 5'd0) &&
          ((RsD == write_reg_m_q) || (RtD == write_reg_m_q)))
        branch_stall = 1'b1;
    end

    if ((rs_e_q != 5'd0) && reg_write_m_q && (rs_e_q == write_reg_m_q))
      ForwardAE = 2'b10;
    else if ((rs_e_q != 5'd0) && reg_write_w_q && (rs_e_q == write_reg_w_q))
      ForwardAE = 2'b01;

    if ((rt_e_q != 5'd0) && reg_write_m_q && (rt_e_q == write_reg_m_q))
      ForwardBE = 2'b10;
    else if ((rt_e_q != 5'd0) && reg_write_w_q && (rt_e_q == write_reg_w_q))
      ForwardBE = 2'b01;

    ForwardAD = (RsD != 5'd0) && reg_write_m_q && (RsD == write_reg_m_q);
    ForwardBD = (RtD != 5'd0) && reg_write_m_q && (RtD == write_reg_m_q);
  end

  assign stall      = lw_stall | branch_stall;
  assign StallF     = stall;
  assign StallD     = stall;
  assign FlushE     = stall;
  assign StallCount = count_q;

  // Shadow registers advance exactly like the real pipeline registers.
  always_comb begin
    rs_e_d         = RsD;
    rt_e_d         = RtD;
    rd_e_d         = RdD;
    reg_dst_e_d    = RegDstD;
    reg_write_e_d  = RegWriteD;
    mem_to_reg_e_d = MemtoRegD;
    if (stall) begin
      rs_e_d         = 5'd0;
      rt_e_d         = 5'd0;
      rd_e_d         = 5'd0;
      reg_dst_e_d    = 1'b0;
      reg_write_e_d  = 1'b0;
      mem_to_reg_e_d = 1'b0;
    end
    write_reg_m_d  = write_reg_e;
    reg_write_m_d  = reg_write_e_q;
    mem_to_reg_m_d = mem_to_reg_e_q;
    write_reg_w_d  = write_reg_m_q;
    reg_write_w_d  = reg_write_m_q;
    count_d        = count_q;
    if (stall && (count_q != {CNT_W{1'b1}}))
      count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rs_e_q         <= 5'd0;
      rt_e_q         <= 5'd0;
      rd_e_q         <= 5'd0;
      reg_dst_e_q    <= 1'b0;
      reg_write_e_q  <= 1'b0;
      mem_to_reg_e_q <= 1'b0;
      write_reg_m_q  <= 5'd0;
      reg_write_m_q  <= 1'b0;
      mem_to_reg_m_q <= 1'b0;
      write_reg_w_q  <= 5'd0;
      reg_write_w_q  <= 1'b0;
      count_q        <= '0;
    end else begin
      rs_e_q         <= rs_e_d;
      rt_e_q         <= rt_e_d;
      rd_e_q         <= rd_e_d;
      reg_dst_e_q    <= reg_dst_e_d;
      reg_write_e_q  <= reg_write_e_d;
      mem_to_reg_e_q <= mem_to_reg_e_d;
      write_reg_m_q  <= write_reg_m_d;
      reg_write_m_q  <= reg_write_m_d;
      mem_to_reg_m_q <= mem_to_reg_m_d;
      write_reg_w_q  <= write_reg_w_d;
      reg_write_w_q  <= reg_write_w_d;
      count_q        <= count_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;

  logic       CLK = 1'b0;
  logic       reset;
  logic [4:0] RsD, RtD, RdD;
  logic       RegDstD, RegWriteD, MemtoRegD, BranchD;

  logic        StallF, StallD, FlushE, ForwardAD, ForwardBD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] StallCount;

  logic        s_stall_f, s_stall_d, s_flush_e, s_fwd_ad, s_fwd_bd;
  logic [1:0]  s_fwd_ae, s_fwd_be;
  logic [3:0]  StallCount4;

  logic [8:0] outs, s_outs;
  assign outs   = {StallF, StallD, FlushE, ForwardAE, ForwardBE, ForwardAD, ForwardBD};
  assign s_outs = {s_stall_f, s_stall_d, s_flush_e, s_fwd_ae, s_fwd_be, s_fwd_ad, s_fwd_bd};

  int total  = 0;
  int passed = 0;

  hazard_unit #(.CNT_W(16)) dut (
    .CLK(CLK), .reset(reset), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .RegDstD(RegDstD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .BranchD(BranchD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .StallCount(StallCount)
  );

  hazard_unit #(.CNT_W(4)) dut_small (
    .CLK(CLK), .reset(reset), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .RegDstD(RegDstD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .BranchD(BranchD),
    .StallF(s_stall_f), .StallD(s_stall_d), .FlushE(s_flush_e),
    .ForwardAE(s_fwd_ae), .ForwardBE(s_fwd_be),
    .ForwardAD(s_fwd_ad), .ForwardBD(s_fwd_bd), .StallCount(StallCount4)
  );

  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic dst, input logic wr, input logic mtr, input logic br);
    RsD = rs; RtD = rt; RdD = rd;
    RegDstD = dst; RegWriteD = wr; MemtoRegD = mtr; BranchD = br;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_d(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));
      #2;
      total++;
      if (outs !== 9'd0 || StallCount !== 16'd0 || s_outs !== 9'd0 || StallCount4 !== 4'd0)
        $display("FAIL reset_hold[%0d]: outs=%b cnt=%0d small=%b cnt4=%0d want all 0",
                 i, outs, StallCount, s_outs, StallCount4);
      else passed++;
      step();
    end
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    total++;
    if (outs !== 9'd0 || StallCount !== 16'd0)
      $display("FAIL reset_release: outs=%b cnt=%0d want 0", outs, StallCount);
    else passed++;
  endtask

  task automatic test_load_use;
    do_reset();
    set_d(5'd0, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    set_d(5'd8, 5'd3, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    total++;
    if ({StallF, StallD, FlushE} !== 3'b111)
      $display("FAIL lu_stall_c1: got %b want 111", {StallF, StallD, FlushE});
    else passed++;
    step();
    total++;
    if ({StallF, StallD, FlushE} !== 3'b000)
      $display("FAIL lu_stall_c2: got %b want 000", {StallF, StallD, FlushE});
    else passed++;
    step();
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b0100)
      $display("FAIL lu_fwd_w: got AE=%b BE=%b want AE=01 BE=00", ForwardAE, ForwardBE);
    else passed++;
    total++;
    if (StallCount !== 16'd1)
      $display("FAIL lu_count: got %0d want 1", StallCount);
    else passed++;
  endtask

  task automatic test_alu_chain;
    do_reset();
    set_d(5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    set_d(5'd9, 5'd9, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    total++;
    if (FlushE !== 1'b0)
      $display("FAIL alu_no_stall: got FlushE=%b want 0", FlushE);
    else passed++;
    step();
    set_d(5'd5, 5'd9, 5'd14, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b1010)
      $display("FAIL alu_fwd_m: got AE=%b BE=%b want 10 10", ForwardAE, ForwardBE);
    else passed++;
    step();
    #1;
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b0001)
      $display("FAIL alu_fwd_w: got AE=%b BE=%b want 00 01", ForwardAE, ForwardBE);
    else passed++;

    do_reset();
    set_d(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    set_d(5'd0, 5'd0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    #1;
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b0000)
      $display("FAIL alu_fwd_r0: got AE=%b BE=%b want 00 00", ForwardAE, ForwardBE);
    else passed++;
  endtask

  task automatic test_zero_reg;
    do_reset();
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    set_d(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    total++;
    if (FlushE !== 1'b0)
      $display("FAIL lw_r0_no_stall: got FlushE=%b want 0", FlushE);
    else passed++;
  endtask

  task automatic test_branch_alu;
    do_reset();
    set_d(5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    set_d(5'd10, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    total++;
    if ({StallF, StallD, FlushE} !== 3'b111)
      $display("FAIL br_alu_stall: got %b want 111", {StallF, StallD, FlushE});
    else passed++;
    step();
    total++;
    if (FlushE !== 1'b0 || {ForwardAD, ForwardBD} !== 2'b10)
      $display("FAIL br_alu_fwd: got FlushE=%b AD=%b BD=%b want 0 1 0",
               FlushE, ForwardAD, ForwardBD);
    else passed++;
    total++;
    if (StallCount !== 16'd1)
      $display("FAIL br_alu_count: got %0d want 1", StallCount);
    else passed++;
  endtask

  task automatic test_branch_load;
    do_reset();
    set_d(5'd4, 5'd11, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    set_d(5'd5, 5'd11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    total++;
    if ({StallF, StallD, FlushE} !== 3'b111)
      $display("FAIL br_lw_stall1: got %b want 111", {StallF, StallD, FlushE});
    else passed++;
    step();
    total++;
    if ({StallF, StallD, FlushE} !== 3'b111)
      $display("FAIL br_lw_stall2: got %b want 111", {StallF, StallD, FlushE});
    else passed++;
    step();
    total++;
    if (FlushE !== 1'b0 || ForwardBD !== 1'b0)
      $display("FAIL br_lw_release: got FlushE=%b BD=%b want 0 0", FlushE, ForwardBD);
    else passed++;
    total++;
    if (StallCount !== 16'd2)
      $display("FAIL br_lw_count: got %0d want 2", StallCount);
    else passed++;
  endtask

  task automatic test_saturation;
    do_reset();
    set_d(5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (20) step();
    total++;
    if (StallCount4 !== 4'd10 || StallCount !== 16'd10)
      $display("FAIL sat_mid: got cnt4=%0d cnt=%0d want 10 10", StallCount4, StallCount);
    else passed++;
    repeat (20) step();
    total++;
    if (StallCount4 !== 4'd15 || StallCount !== 16'd20)
      $display("FAIL sat_hold: got cnt4=%0d cnt=%0d want 15 20", StallCount4, StallCount);
    else passed++;
    step();
    total++;
    if (FlushE !== 1'b1 || s_flush_e !== 1'b1)
      $display("FAIL sat_stalling: got FlushE=%b small=%b want 1 1", FlushE, s_flush_e);
    else passed++;
    reset = 1'b0;
    #1;
    total++;
    if (FlushE !== 1'b0 || s_flush_e !== 1'b0 || StallCount !== 16'd0 || StallCount4 !== 4'd0)
      $display("FAIL reset_mid_stall: got FlushE=%b small=%b cnt=%0d cnt4=%0d want 0 0 0 0",
               FlushE, s_flush_e, StallCount, StallCount4);
    else passed++;
    step();
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_load_use();
    test_alu_chain();
    test_zero_reg();
    test_branch_alu();
    test_branch_load();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
